// File: rtl/cc_psr_branch.sv
// Condition-code consumer: latches ALU flags into icc, resolves 4-bit branch conditions, counts branches.
// Optional trap-on-overflow logic is built when CC_PSR_TRAP_EN is defined.
module cc_psr_branch #(
  parameter int unsigned DATAWIDTH_COND  = 4,
  parameter int unsigned DATAWIDTH_COUNT = 16
) (
  input  logic                       CC_PSR_CLOCK_50,
  input  logic                       CC_PSR_RESET_InLow,
  input  logic                       CC_PSR_negative_InHigh,
  input  logic                       CC_PSR_zero_InHigh,
  input  logic                       CC_PSR_overflow_InHigh,
  input  logic                       CC_PSR_carry_InHigh,
  input  logic                       CC_PSR_scc_InHigh,
  input  logic                       CC_PSR_load_InHigh,
  input  logic [DATAWIDTH_COND-1:0]  CC_PSR_cond_InBUS,
  input  logic                       CC_PSR_branchReq_InHigh,
`ifdef CC_PSR_TRAP_EN
  input  logic                       CC_PSR_trapAck_InHigh,
  output logic                       CC_PSR_trapReq_OutHigh,
`endif
  output logic [3:0]                 CC_PSR_icc_OutBUS,
  output logic                       CC_PSR_branchValid_OutHigh,
  output logic                       CC_PSR_branchTaken_OutHigh,
  output logic [DATAWIDTH_COUNT-1:0] CC_PSR_branchCount_OutBUS,
  output logic [DATAWIDTH_COUNT-1:0] CC_PSR_takenCount_OutBUS
);

  typedef enum logic {
    stIdle,
    stResolve
  } stateT;

  localparam logic [DATAWIDTH_COUNT-1:0] cntOne = DATAWIDTH_COUNT'(1);

  stateT      state;
  logic       commit;
  logic [3:0] newFlags;
  logic [3:0] effFlags;
  logic       decision;

  assign commit   = CC_PSR_scc_InHigh & CC_PSR_load_InHigh;
  assign newFlags = {CC_PSR_negative_InHigh, CC_PSR_zero_InHigh,
                     CC_PSR_overflow_InHigh, CC_PSR_carry_InHigh};
  // Forward the committing flags so a branch in the compare cycle sees them.
  assign effFlags = commit ? newFlags : CC_PSR_icc_OutBUS;

  // Upper eight conditions are the complements of the lower eight.
  function automatic logic condTaken(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, v, c, base;
    n = f[3];
    z = f[2];
    v = f[1];
    c = f[0];
    unique case (cond[2:0])
      3'd0:    base = 1'b0;
      3'd1:    base = z;
      3'd2:    base = z | (n ^ v);
      3'd3:    base = n ^ v;
      3'd4:    base = c | z;
      3'd5:    base = c;
      3'd6:    base = n;
      default: base = v;
    endcase
    return base ^ cond[3];
  endfunction

  assign decision = condTaken(CC_PSR_cond_InBUS[3:0], effFlags);

  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      CC_PSR_icc_OutBUS <= '0;
    end else if (commit) begin
      CC_PSR_icc_OutBUS <= newFlags;
    end
  end

  // Counters advance on the edge that registers a decision, so they line up with the valid pulse.
  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      state                      <= stIdle;
      CC_PSR_branchValid_OutHigh <= 1'b0;
      CC_PSR_branchTaken_OutHigh <= 1'b0;
      CC_PSR_branchCount_OutBUS  <= '0;
      CC_PSR_takenCount_OutBUS   <= '0;
    end else begin
      case (state)
        stIdle, stResolve: begin
          if (CC_PSR_branchReq_InHigh) begin
            state                      <= stResolve;
            CC_PSR_branchValid_OutHigh <= 1'b1;
            CC_PSR_branchTaken_OutHigh <= decision;
            if (CC_PSR_branchCount_OutBUS != '1) begin
              CC_PSR_branchCount_OutBUS <= CC_PSR_branchCount_OutBUS + cntOne;
            end
            if (decision && (CC_PSR_takenCount_OutBUS != '1)) begin
              CC_PSR_takenCount_OutBUS <= CC_PSR_takenCount_OutBUS + cntOne;
            end
          end else begin
            state                      <= stIdle;
            CC_PSR_branchValid_OutHigh <= 1'b0;
            CC_PSR_branchTaken_OutHigh <= 1'b0;
          end
        end
        default: begin
          state                      <= stIdle;
          CC_PSR_branchValid_OutHigh <= 1'b0;
          CC_PSR_branchTaken_OutHigh <= 1'b0;
        end
      endcase
    end
  end

`ifdef CC_PSR_TRAP_EN
  // A fresh overflow commit wins over a same-cycle acknowledge.
  always_ff @(posedge CC_PSR_CLOCK_50 or negedge CC_PSR_RESET_InLow) begin
    if (!CC_PSR_RESET_InLow) begin
      CC_PSR_trapReq_OutHigh <= 1'b0;
    end else if (commit && CC_PSR_overflow_InHigh) begin
      CC_PSR_trapReq_OutHigh <= 1'b1;
    end else if (CC_PSR_trapAck_InHigh) begin
      CC_PSR_trapReq_OutHigh <= 1'b0;
    end
  end
`endif

endmodule
